// File: rtl/div_unit.sv
// div_unit: iterative 32-bit integer divider for RV32M DIV/DIVU/REM/REMU.
//
// Sits in the execute stage. A request is accepted when Start_i=1 while the
// unit is idle and not being flushed. Normal operations run a restoring
// shift-subtract for 32 cycles, followed by one sign-fix cycle and one done
// cycle. Divide-by-zero and signed overflow skip straight to done.
//
// Ports:
//   Clk_i       rising-edge clock
//   Rst_ni      asynchronous active-low reset
//   Start_i     request (accepted only when idle and Flush_i=0)
//   OperandA_i  dividend, sampled on acceptance
//   OperandB_i  divisor, sampled on acceptance
//   DivOp_i     00=DIV 01=DIVU 10=REM 11=REMU, sampled on acceptance
//   Flush_i     abort the operation in flight
//   Busy_o      high whenever the unit is not idle
//   Done_o      one-cycle pulse, Result_o valid in the same cycle
//   Result_o    quotient or remainder, held until the next result
module div_unit (
    input  logic        Clk_i,
    input  logic        Rst_ni,
    input  logic        Start_i,
    input  logic [31:0] OperandA_i,
    input  logic [31:0] OperandB_i,
    input  logic [1:0]  DivOp_i,
    input  logic        Flush_i,
    output logic        Busy_o,
    output logic        Done_o,
    output logic [31:0] Result_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q,  state_d;
    logic [4:0]  cnt_q,    cnt_d;
    logic [1:0]  op_q,     op_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic [31:0] quo_q,    quo_d;     // dividend shifts out, quotient shifts in
    logic [31:0] dvs_q,    dvs_d;
    logic [31:0] rem_q,    rem_d;
    logic [31:0] result_q, result_d;

    logic        in_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        in_overflow;
    logic [32:0] rem_shift;
    logic [32:0] diff;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        result_d = result_q;

        // Operand decode at acceptance. Negating 0x80000000 yields 0x80000000,
        // which is the correct magnitude when read as unsigned.
        in_signed   = ~DivOp_i[0];
        abs_a       = (in_signed && OperandA_i[31]) ? -OperandA_i : OperandA_i;
        abs_b       = (in_signed && OperandB_i[31]) ? -OperandB_i : OperandB_i;
        in_overflow = in_signed && (OperandA_i == 32'h8000_0000) &&
                      (OperandB_i == 32'hFFFF_FFFF);

        // One restoring step: the partial remainder never exceeds the divisor,
        // so 33 bits are enough to hold the shifted value and the borrow.
        rem_shift = {rem_q, quo_q[31]};
        diff      = rem_shift - {1'b0, dvs_q};

        // Sign correction: quotient sign is signA^signB, remainder follows A.
        quo_fix = (~op_q[0] && (sign_a_q ^ sign_b_q)) ? -quo_q : quo_q;
        rem_fix = (~op_q[0] && sign_a_q) ? -rem_q : rem_q;

        case (state_q)
            S_IDLE: begin
                if (Start_i && !Flush_i) begin
                    op_d     = DivOp_i;
                    sign_a_d = OperandA_i[31];
                    sign_b_d = OperandB_i[31];
                    cnt_d    = 5'd0;
                    if (OperandB_i == 32'd0) begin
                        result_d = DivOp_i[1] ? OperandA_i : 32'hFFFF_FFFF;
                        state_d  = S_DONE;
                    end else if (in_overflow) begin
                        result_d = DivOp_i[1] ? 32'd0 : 32'h8000_0000;
                        state_d  = S_DONE;
                    end else begin
                        quo_d   = abs_a;
                        dvs_d   = abs_b;
                        rem_d   = 32'd0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (!diff[32]) begin
                    rem_d = diff[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_shift[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = op_q[1] ? rem_fix : quo_fix;
                state_d  = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A flush abandons the operation and must not disturb the last result.
        if (Flush_i && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            op_q     <= 2'd0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            quo_q    <= 32'd0;
            dvs_q    <= 32'd0;
            rem_q    <= 32'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    assign Busy_o   = (state_q != S_IDLE);
    assign Done_o   = (state_q == S_DONE);
    assign Result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit. Directed cases plus
// randomized operations compared against an arithmetic reference model.
module tb_div_unit;

    logic        Clk_i;
    logic        Rst_ni;
    logic        Start_i;
    logic [31:0] OperandA_i;
    logic [31:0] OperandB_i;
    logic [1:0]  DivOp_i;
    logic        Flush_i;
    logic        Busy_o;
    logic        Done_o;
    logic [31:0] Result_o;

    int checks;
    int failures;

    div_unit dut (
        .Clk_i      (Clk_i),
        .Rst_ni     (Rst_ni),
        .Start_i    (Start_i),
        .OperandA_i (OperandA_i),
        .OperandB_i (OperandB_i),
        .DivOp_i    (DivOp_i),
        .Flush_i    (Flush_i),
        .Busy_o     (Busy_o),
        .Done_o     (Done_o),
        .Result_o   (Result_o)
    );

    initial Clk_i = 1'b0;
    always #5 Clk_i = ~Clk_i;

    // Reference: RISC-V M-extension semantics in plain arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        int sa;
        int sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'b00:   return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
            2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] op,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request from idle and follow it to completion. Called at #1
    // after a clock edge; returns at #1 after the edge following Done_o.
    task automatic do_op(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        int cyc;
        logic bad;
        logic [31:0] prev;
        prev       = Result_o;
        bad        = 1'b0;
        DivOp_i    = op;
        OperandA_i = a;
        OperandB_i = b;
        Start_i    = 1'b1;
        @(posedge Clk_i); #1;
        Start_i = 1'b0;
        cyc     = 1;
        while (!Done_o && cyc < 40) begin
            if (!Busy_o || Result_o !== prev) bad = 1'b1;
            @(posedge Clk_i); #1;
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(ref_latency(op, a, b)));
        chk({tag, "_busy_hold"}, {31'd0, bad}, 32'd0);
        chk({tag, "_result"}, Result_o, ref_result(op, a, b));
        chk({tag, "_busy_done"}, {31'd0, Busy_o}, 32'd1);
        @(posedge Clk_i); #1;
        chk({tag, "_idle_after"}, {30'd0, Busy_o, Done_o}, 32'd0);
    endtask

    initial begin
        int cyc;
        logic bad;
        logic [31:0] prev;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int sel;

        checks     = 0;
        failures   = 0;
        Rst_ni     = 1'b0;
        Start_i    = 1'b0;
        Flush_i    = 1'b0;
        DivOp_i    = 2'b00;
        OperandA_i = 32'd0;
        OperandB_i = 32'd0;
        repeat (3) @(posedge Clk_i);
        #1;
        chk("reset_outputs", {Busy_o, Done_o, Result_o[29:0]}, 32'd0);
        chk("reset_result", Result_o, 32'd0);
        Rst_ni = 1'b1;

        // Directed cases
        do_op("divu_100_7", 2'b01, 32'd100, 32'd7);
        do_op("remu_100_7", 2'b11, 32'd100, 32'd7);
        do_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2);
        do_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2);
        do_op("div_7_m2",   2'b00, 32'd7, 32'hFFFF_FFFE);
        do_op("div_by0",    2'b00, 32'd5, 32'd0);
        do_op("rem_by0",    2'b10, 32'd5, 32'd0);
        do_op("remu_by0",   2'b11, 32'hFFFF_FFFF, 32'd0);
        do_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("divu_ovfops", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("rem_minint", 2'b10, 32'h8000_0000, 32'd3);
        chk("known_divu_val", ref_result(2'b01, 32'd100, 32'd7), 32'd14);

        // Flush in cycle 10 of DIVU 100/7
        prev       = Result_o;
        bad        = 1'b0;
        DivOp_i    = 2'b01;
        OperandA_i = 32'd100;
        OperandB_i = 32'd7;
        Start_i    = 1'b1;
        @(posedge Clk_i); #1;
        Start_i = 1'b0;
        repeat (9) begin
            if (Done_o) bad = 1'b1;
            @(posedge Clk_i); #1;
        end
        Flush_i = 1'b1;
        @(posedge Clk_i); #1;
        Flush_i = 1'b0;
        chk("flush_busy", {31'd0, Busy_o}, 32'd0);
        chk("flush_done", {31'd0, Done_o | bad}, 32'd0);
        chk("flush_result_kept", Result_o, prev);
        do_op("after_flush", 2'b01, 32'd100, 32'd7);

        // Start with Flush in idle is not accepted
        Start_i = 1'b1;
        Flush_i = 1'b1;
        DivOp_i = 2'b01;
        @(posedge Clk_i); #1;
        Start_i = 1'b0;
        Flush_i = 1'b0;
        chk("start_flush_idle_busy", {31'd0, Busy_o}, 32'd0);
        @(posedge Clk_i); #1;
        chk("start_flush_idle_done", {31'd0, Done_o}, 32'd0);

        // Start held high with operands changed mid-operation
        DivOp_i    = 2'b01;
        OperandA_i = 32'd100;
        OperandB_i = 32'd7;
        Start_i    = 1'b1;
        @(posedge Clk_i); #1;
        OperandA_i = 32'd1000;
        OperandB_i = 32'd10;
        cyc = 1;
        while (!Done_o && cyc < 40) begin
            @(posedge Clk_i); #1;
            cyc++;
        end
        chk("held_latency", 32'(cyc), 32'd34);
        chk("held_result", Result_o, 32'd14);
        @(posedge Clk_i); #1;
        chk("held_idle_c35", {31'd0, Busy_o}, 32'd0);
        @(posedge Clk_i); #1;
        Start_i = 1'b0;
        chk("held_second_accepted", {31'd0, Busy_o}, 32'd1);
        cyc = 36;
        while (!Done_o && cyc < 80) begin
            @(posedge Clk_i); #1;
            cyc++;
        end
        chk("held_second_latency", 32'(cyc), 32'd69);
        chk("held_second_result", Result_o, 32'd100);
        @(posedge Clk_i); #1;

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2:       rb = $urandom_range(1, 15);
                3:       rb = -($urandom_range(1, 15));
                4:       rb = ra + 32'd1;
                default: rb = $urandom;
            endcase
            do_op($sformatf("rand%0d", i), rop, ra, rb);
        end

        // Asynchronous reset pulse mid-operation (cycle 20)
        DivOp_i    = 2'b01;
        OperandA_i = 32'd100;
        OperandB_i = 32'd7;
        Start_i    = 1'b1;
        @(posedge Clk_i); #1;
        Start_i = 1'b0;
        repeat (19) @(posedge Clk_i);
        #3;
        Rst_ni = 1'b0;
        #1;
        chk("rst_async_ctrl", {30'd0, Busy_o, Done_o}, 32'd0);
        chk("rst_async_result", Result_o, 32'd0);
        @(posedge Clk_i); #1;
        Rst_ni = 1'b1;
        bad = 1'b0;
        repeat (40) begin
            if (Done_o || Busy_o) bad = 1'b1;
            @(posedge Clk_i); #1;
        end
        chk("rst_no_done", {31'd0, bad}, 32'd0);
        do_op("after_reset", 2'b00, 32'hFFFF_FF9C, 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
